// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display driver and the scan reader.
// Keeping the code table here gives the encoder and the decoder one source for it.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int BCD_W = 4;

    // {a,b,c,d,e,f,g}, a = MSB, active-high
    localparam logic [SEG_W-1:0] SEG_CODE [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder.
// A pattern outside the decimal code table decodes to BCD_INVALID and raises o_invalid.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [BCD_W-1:0] o_nibble,
    output logic             o_invalid
);

    always_comb begin
        o_nibble  = BCD_INVALID;
        o_invalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (i_seg == SEG_CODE[k]) begin
                o_nibble  = BCD_W'(k);
                o_invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reader for a multiplexed 7-segment bus: debounces each scanned digit, decodes it to BCD
// and hands one assembled frame per full scan to a valid/ready consumer.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   COLLECT | capturing stable digits into the shadow word until all are seen
//   HOLD    | frame presented on bcd/frame_err; waits for frame_ready
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIGITS-1:0]       dig_sel,
    input  logic [SEG_W-1:0]        seg,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err
);

    localparam int                CNT_W   = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [DIGITS-1:0]             r_sel;
    logic [SEG_W-1:0]              r_seg;
    logic [CNT_W-1:0]              r_cnt;
    logic [DIGITS-1:0]             r_captured;
    logic [DIGITS-1:0][BCD_W-1:0]  r_shadow;
    logic                          r_err_acc;
    state_t                        r_state;
    logic [BCD_W*DIGITS-1:0]       r_bcd;
    logic                          r_valid;
    logic                          r_err;

    logic                          w_same;
    logic                          w_onehot;
    logic [CNT_W-1:0]              w_cnt_nxt;
    logic                          w_capture;
    logic [DIGITS-1:0]             w_cap_vec;
    logic [BCD_W-1:0]              w_nibble;
    logic                          w_invalid;

    assign w_same   = (dig_sel == r_sel) && (seg == r_seg);
    assign w_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);

    // The capture fires on the edge where the count reaches its terminal value, so a
    // pattern present for STABLE_CYC edges (one sample plus STABLE_CYC-1 repeats) is taken.
    always_comb begin
        w_cnt_nxt = '0;
        if (w_onehot && w_same) begin
            w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_W'(1);
        end
    end

    assign w_capture = (r_state == COLLECT) && (w_cnt_nxt == CNT_MAX);
    assign w_cap_vec = w_capture ? (r_sel & ~r_captured) : '0;

    seg7_to_bcd u_dec (
        .i_seg     (r_seg),
        .o_nibble  (w_nibble),
        .o_invalid (w_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel      <= '0;
            r_seg      <= '0;
            r_cnt      <= '0;
            r_captured <= '0;
            r_shadow   <= '0;
            r_err_acc  <= 1'b0;
            r_state    <= COLLECT;
            r_bcd      <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_sel <= dig_sel;
            r_seg <= seg;
            r_cnt <= w_cnt_nxt;
            if (r_state == COLLECT) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (w_cap_vec[i]) begin
                        r_shadow[i] <= w_nibble;
                    end
                end
                if (|w_cap_vec) begin
                    r_err_acc <= r_err_acc | w_invalid;
                end
                r_captured <= r_captured | w_cap_vec;
                if (&r_captured) begin
                    r_state <= HOLD;
                    r_bcd   <= r_shadow;
                    r_err   <= r_err_acc;
                    r_valid <= 1'b1;
                end
            end else if (r_valid && frame_ready) begin
                r_valid    <= 1'b0;
                r_captured <= '0;
                r_err_acc  <= 1'b0;
                r_state    <= COLLECT;
            end
        end
    end

    assign bcd         = r_bcd;
    assign frame_valid = r_valid;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed scans plus random scans scored
// against a hold-level reference model (first hold of >= STABLE_CYC cycles per digit wins).
module tb_seg7_scan_reader;

    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dig_sel;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_scan_reader #(.DIGITS(4), .STABLE_CYC(STABLE_CYC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dig_sel     (dig_sel),
        .seg         (seg),
        .bcd         (bcd),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err)
    );

    logic [6:0] ref_code [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct {
        logic [3:0] sel;
        logic [6:0] sg;
        int         dur;
    } hold_t;

    hold_t       scan_q[$];
    logic [16:0] acc_q[$];

    // Record every accepted frame; inputs change at posedge+2 so negedge is race-free.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1 && frame_ready === 1'b1)
            acc_q.push_back({frame_err, bcd});
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold(input logic [3:0] sel, input logic [6:0] sg, input int n);
        dig_sel = sel;
        seg     = sg;
        step(n);
    endtask

    task automatic add(input logic [3:0] sel, input logic [6:0] sg, input int dur);
        hold_t h;
        h.sel = sel;
        h.sg  = sg;
        h.dur = dur;
        scan_q.push_back(h);
    endtask

    task automatic run_scan();
        foreach (scan_q[i]) begin
            hold(scan_q[i].sel, scan_q[i].sg, scan_q[i].dur);
            hold(4'b0000, 7'b0000000, 1);
        end
        scan_q.delete();
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h1F;
        for (int k = 0; k < 10; k++)
            if (s == ref_code[k]) r = {1'b0, 4'(k)};
        return r;
    endfunction

    task automatic model(output logic [15:0] eb, output logic ee);
        bit         cap [4];
        logic [4:0] dec;
        int         d;
        eb = '0;
        ee = 1'b0;
        foreach (cap[i]) cap[i] = 1'b0;
        foreach (scan_q[i]) begin
            if ($countones(scan_q[i].sel) == 1 && scan_q[i].dur >= STABLE_CYC) begin
                d = $clog2(scan_q[i].sel);
                if (!cap[d]) begin
                    dec        = ref_decode(scan_q[i].sg);
                    eb[4*d +: 4] = dec[3:0];
                    ee         = ee | dec[4];
                    cap[d]     = 1'b1;
                end
            end
        end
    endtask

    // Expects frame_ready already high; leaves it low after the handshake edge.
    task automatic get_frame(input string tag, input logic [15:0] eb, input logic ee);
        bit          got;
        logic [16:0] f;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            @(negedge clk);
            if (acc_q.size() > 0) got = 1'b1;
        end
        chk({tag, "_arrived"}, 32'(got), 32'd1);
        if (got) begin
            f = acc_q.pop_front();
            chk({tag, "_bcd"}, 32'(f[15:0]), 32'(eb));
            chk({tag, "_err"}, 32'(f[16]), 32'(ee));
        end
        @(posedge clk);
        #2;
        frame_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] eb;
        logic        ee;
        logic [3:0]  one;
        int          ord [4];
        int          j, tmp;

        one         = 4'b0001;
        rst_n       = 1'b0;
        frame_ready = 1'b0;
        dig_sel     = '0;
        seg         = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            dig_sel = 4'($urandom_range(0, 15));
            seg     = 7'($urandom_range(0, 127));
            step(1);
        end
        @(negedge clk);
        chk("rst_bcd",   32'(bcd),         32'd0);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_err",   32'(frame_err),   32'd0);
        dig_sel = '0;
        seg     = '0;
        step(1);
        rst_n = 1'b1;
        step(2);

        // Plain scan 2,0,2,5 with ready held high
        frame_ready = 1'b1;
        add(4'b1000, ref_code[2], 6);
        add(4'b0100, ref_code[0], 6);
        add(4'b0010, ref_code[2], 6);
        add(4'b0001, ref_code[5], 6);
        run_scan();
        get_frame("scan2025", 16'h2025, 1'b0);

        // Glitch on digit 0 shorter than the stability window
        add(4'b0001, 7'b0110000, STABLE_CYC - 1);
        add(4'b0001, 7'b1111110, 6);
        add(4'b0010, ref_code[6], 6);
        add(4'b0100, ref_code[5], 6);
        add(4'b1000, ref_code[4], 6);
        run_scan();
        frame_ready = 1'b1;
        get_frame("glitch", 16'h4560, 1'b0);

        // Non-decimal pattern on digit 2
        add(4'b1000, ref_code[7], 6);
        add(4'b0100, 7'b0000000, 6);
        add(4'b0010, ref_code[7], 6);
        add(4'b0001, ref_code[7], 6);
        run_scan();
        frame_ready = 1'b1;
        get_frame("invalid", 16'h7F77, 1'b1);

        // Backpressure: frame 1234 held while 9999 is scanned
        add(4'b1000, ref_code[1], 6);
        add(4'b0100, ref_code[2], 6);
        add(4'b0010, ref_code[3], 6);
        add(4'b0001, ref_code[4], 6);
        run_scan();
        @(negedge clk);
        chk("bp_valid_up", 32'(frame_valid), 32'd1);
        for (int d = 0; d < 4; d++) add(one << d, ref_code[9], 6);
        run_scan();
        @(negedge clk);
        chk("bp_valid_held", 32'(frame_valid), 32'd1);
        chk("bp_bcd_held",   32'(bcd),         32'h1234);
        chk("bp_no_accept",  32'(acc_q.size()), 32'd0);
        frame_ready = 1'b1;
        get_frame("bp_old", 16'h1234, 1'b0);
        for (int d = 0; d < 4; d++) add(one << d, ref_code[9], 6);
        run_scan();
        frame_ready = 1'b1;
        get_frame("bp_new", 16'h9999, 1'b0);

        // Asynchronous reset asserted mid-cycle while a frame is presented
        for (int d = 0; d < 4; d++) add(one << d, ref_code[8], 6);
        run_scan();
        @(negedge clk);
        chk("arst_pre_valid", 32'(frame_valid), 32'd1);
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(frame_valid), 32'd0);
        chk("arst_bcd",   32'(bcd),         32'd0);
        chk("arst_err",   32'(frame_err),   32'd0);
        hold(4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)), 2);
        hold(4'b0000, 7'b0000000, 1);
        rst_n = 1'b1;
        step(2);

        // Reset after two captures discards the partial frame
        add(4'b0001, ref_code[3], 6);
        add(4'b0010, ref_code[1], 6);
        run_scan();
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        add(4'b0100, ref_code[6], 6);
        add(4'b1000, ref_code[7], 6);
        run_scan();
        hold(4'b0000, 7'b0000000, 10);
        @(negedge clk);
        chk("partial_no_valid", 32'(frame_valid), 32'd0);
        hold(4'b0011, ref_code[8], 10);
        hold(4'b0000, 7'b0000000, 1);
        @(negedge clk);
        chk("overlap_no_valid", 32'(frame_valid), 32'd0);
        add(4'b0001, ref_code[4], 6);
        add(4'b0010, ref_code[5], 6);
        run_scan();
        frame_ready = 1'b1;
        get_frame("recapture", 16'h7654, 1'b0);

        // Random scans: noisy passes in random order, then a guaranteed clean pass
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 3; p++) begin
                for (int i = 0; i < 4; i++) ord[i] = i;
                for (int i = 3; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
                end
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 5) == 0)
                        add(one << ord[i], 7'($urandom_range(0, 127)),
                            (p == 2) ? 5 : $urandom_range(1, 7));
                    else
                        add(one << ord[i], ref_code[$urandom_range(0, 9)],
                            (p == 2) ? 5 : $urandom_range(1, 7));
                end
            end
            model(eb, ee);
            run_scan();
            frame_ready = 1'b1;
            get_frame($sformatf("rand%0d", f), eb, ee);
        end

        step(4);
        chk("no_extra_frames", 32'(acc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
